clkdiv_select_monitor: RTL and testbench
========================================

CLKDIV_SELECT_MONITOR -- requirements
Module: clkdiv_select_monitor

Downstream consumer of the even-ratio clock divider outputs. It selects one of div2/div4/div6 glitch-free, generates rise-edge enable pulses and checks the measured period.

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high (ports clk, reset).
REQ-002 Ports (name, direction, width, meaning):
  clk           in   1  system clock; divider inputs are synchronous to it
  reset         in   1  synchronous, active-high
  div2          in   1  divide-by-2 level from upstream divider
  div4          in   1  divide-by-4 level
  div6          in   1  divide-by-6 level
  sel           in   2  00=div2, 01=div4, 10=div6, 11=reserved
  sel_load      in   1  one-cycle request to switch to sel
  div_out       out  1  selected divided clock, registered, glitch-free across switches
  rise_pulse    out  1  one-cycle pulse per rising edge of the active source
  period        out  4  clk cycles between the last two active rises, saturating at 15
  period_valid  out  1  one-cycle pulse when period is updated with a real measurement
  period_err    out  1  one-cycle pulse: period_valid and period != expected (2/4/6)
  switching     out  1  high while the switch state machine is not in RUN

Function
REQ-003 SHALL register each divN input into s_N every cycle, and s_N into p_N; rise_N = s_N & ~p_N.
REQ-004 rise_pulse SHALL be high in the cycle after edge N+1, where N is the edge at which the active input is first sampled 1.
REQ-005 rise_pulse SHALL only fire in state RUN.
REQ-006 State machine SHALL have states RUN, WAIT_OLD and WAIT_NEW.
REQ-007 In RUN, div_out <= s_active.
REQ-008 In RUN, a sel_load with sel not in {11, active} SHALL latch pending=sel and go to WAIT_OLD.
REQ-009 In RUN, a sel_load with sel=11 or sel=active SHALL be ignored.
REQ-010 In WAIT_OLD, div_out <= s_active.
REQ-011 In WAIT_OLD, when s_active==0, div_out SHALL be driven 0 and the FSM SHALL go to WAIT_NEW.
REQ-012 In WAIT_NEW, div_out SHALL be held 0.
REQ-013 In WAIT_NEW, when s_pending==0, active <= pending and the FSM SHALL go to RUN.
REQ-014 sel_load SHALL be ignored while switching=1.
REQ-015 div_out SHALL never show a high pulse shorter than the high phase of either source.
REQ-016 Counter cnt (4 bits) SHALL operate only in RUN.
REQ-017 On rise_active, cnt SHALL be set to 1; otherwise cnt increments, saturating at 15.
REQ-018 On rise_active with armed=1, period <= cnt and period_valid SHALL pulse together with rise_pulse.
REQ-019 armed SHALL be cleared by reset and on entry to WAIT_OLD.
REQ-020 armed SHALL be set on the first rise_active in RUN; that first rise SHALL produce rise_pulse but no period_valid.
REQ-021 Expected period SHALL be 2, 4 or 6 for active = 00, 01 or 10 respectively.
REQ-022 period_err SHALL pulse with period_valid on mismatch; period holds its value between updates.
REQ-023 Saturated period=15 SHALL always flag period_err.

Reset
REQ-024 While reset=1 at a clk edge, the following SHALL be forced next cycle: div_out=0, rise_pulse=0, period=0, period_valid=0, period_err=0, switching=0; state RUN; active=00; armed=0; cnt=0; all s_N/p_N=0.
REQ-025 Reset SHALL take priority over sel_load and over any switch in progress.

Verification
REQ-026 Reset 2 cycles, release, drive div2 toggling every clk -> rise_pulse every 2 cycles; first period_valid on second rise with period=2, period_err=0.
REQ-027 sel=01 with sel_load for 1 cycle -> switching=1; div_out low once div2 is sampled low, then follows div4; period_valid only from second div4 rise with period=4, no err.
REQ-028 Then sel=10 with sel_load -> same sequence, period=6. Then sel=11 or sel=10 with sel_load -> switching stays 0, div_out unchanged.
REQ-029 sel_load sel=00 issued while switching=1 -> ignored; the FSM completes the original switch.
REQ-030 On div4 stream, stretch one high phase by 1 cycle -> period=5 with period_err pulse. Hold div4 at 0 for 20 cycles -> next rise gives period=15 with period_err.
REQ-031 Assert reset in WAIT_OLD -> next cycle all outputs at reset values, active=div2; first period_valid after release follows REQ-020.

Source files
------------

// File: rtl/clkdiv_select_monitor.sv
// Glitch-free selector over the div2/div4/div6 levels with rise-edge pulses and
// a period monitor that checks each measured period against the selected ratio.
module clkdiv_select_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic       div2,
  input  logic       div4,
  input  logic       div6,
  input  logic [1:0] sel,
  input  logic       sel_load,
  output logic       div_out,
  output logic       rise_pulse,
  output logic [3:0] period,
  output logic       period_valid,
  output logic       period_err,
  output logic       switching
);

  typedef enum logic [1:0] {RUN, WAIT_OLD, WAIT_NEW} state_t;

  state_t     state_reg, state_next;
  logic [2:0] s_reg, p_reg, rise;
  logic [3:0] s_vec, rise_vec;
  logic [1:0] active_reg, active_next;
  logic [1:0] pending_reg, pending_next;
  logic       armed_reg, armed_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       s_active, s_pending, rise_active;
  logic       div_next, rise_next, pv_next, perr_next;
  logic [3:0] period_next;

  function automatic logic [3:0] expected_period(input logic [1:0] a);
    case (a)
      2'b00:   expected_period = 4'd2;
      2'b01:   expected_period = 4'd4;
      default: expected_period = 4'd6;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rise
      assign rise[gi] = s_reg[gi] & ~p_reg[gi];
    end
  endgenerate

  // Padded to 4 bits so the unused select code 11 indexes a constant 0.
  assign s_vec       = {1'b0, s_reg};
  assign rise_vec    = {1'b0, rise};
  assign s_active    = s_vec[active_reg];
  assign s_pending   = s_vec[pending_reg];
  assign rise_active = rise_vec[active_reg];
  assign switching   = (state_reg != RUN);

  always_comb begin
    state_next   = state_reg;
    active_next  = active_reg;
    pending_next = pending_reg;
    armed_next   = armed_reg;
    cnt_next     = cnt_reg;
    div_next     = 1'b0;
    rise_next    = 1'b0;
    pv_next      = 1'b0;
    perr_next    = 1'b0;
    period_next  = period;
    case (state_reg)
      RUN: begin
        div_next = s_active;
        if (rise_active) begin
          rise_next  = 1'b1;
          cnt_next   = 4'd1;
          armed_next = 1'b1;
          if (armed_reg) begin
            period_next = cnt_reg;
            pv_next     = 1'b1;
            perr_next   = (cnt_reg != expected_period(active_reg));
          end
        end else if (cnt_reg != 4'd15) begin
          cnt_next = cnt_reg + 4'd1;
        end
        // A switch request overrides the arming done by a coincident rise.
        if (sel_load && (sel != 2'b11) && (sel != active_reg)) begin
          pending_next = sel;
          armed_next   = 1'b0;
          state_next   = WAIT_OLD;
        end
      end
      WAIT_OLD: begin
        div_next = s_active;
        if (!s_active) begin
          state_next = WAIT_NEW;
        end
      end
      WAIT_NEW: begin
        if (!s_pending) begin
          active_next = pending_reg;
          state_next  = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      s_reg        <= 3'b000;
      p_reg        <= 3'b000;
      active_reg   <= 2'b00;
      pending_reg  <= 2'b00;
      armed_reg    <= 1'b0;
      cnt_reg      <= 4'd0;
      div_out      <= 1'b0;
      rise_pulse   <= 1'b0;
      period       <= 4'd0;
      period_valid <= 1'b0;
      period_err   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s_reg        <= {div6, div4, div2};
      p_reg        <= s_reg;
      active_reg   <= active_next;
      pending_reg  <= pending_next;
      armed_reg    <= armed_next;
      cnt_reg      <= cnt_next;
      div_out      <= div_next;
      rise_pulse   <= rise_next;
      period       <= period_next;
      period_valid <= pv_next;
      period_err   <= perr_next;
    end
  end

endmodule

// File: tb/tb_clkdiv_select_monitor.sv
// Randomized scoreboard bench: a timestamp-based reference model predicts every
// rise event and the per-cycle div_out/switching/period, a negedge monitor checks.
module tb_clkdiv_select_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       div2 = 1'b0, div4 = 1'b0, div6 = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       sel_load = 1'b0;
  logic       div_out, rise_pulse, period_valid, period_err, switching;
  logic [3:0] period;

  always #5 clk = ~clk;

  clkdiv_select_monitor dut (
    .clk(clk), .reset(reset), .div2(div2), .div4(div4), .div6(div6),
    .sel(sel), .sel_load(sel_load), .div_out(div_out), .rise_pulse(rise_pulse),
    .period(period), .period_valid(period_valid), .period_err(period_err),
    .switching(switching)
  );

  typedef struct {int cyc; bit pv; int per; bit perr;} ev_t;
  typedef struct {bit div; bit sw; int per;} cy_t;
  ev_t evq[$];
  cy_t cyq[$];
  int  n_checks = 0, n_fail = 0, edge_no = 0;

  // Source generators: half period of source i is i+1 clocks.
  bit lv[3], extra[3], stretch_req[3];
  int ph[3];
  int hold4 = 0;

  // Reference model state.
  bit ms[3], mp[3];
  int m_mode = 0, m_active = 0, m_pending = 0, m_last = 0, m_period = 0;
  bit m_armed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual=%0d expected=%0d", nm, edge_no, act, exp);
    end
  endtask

  task automatic gen_sources();
    for (int i = 0; i < 3; i++) begin
      if (i == 1 && hold4 > 0) begin
        lv[1] = 1'b0; ph[1] = 0; hold4--;
      end else begin
        if (stretch_req[i] && lv[i]) begin extra[i] = 1'b1; stretch_req[i] = 1'b0; end
        ph[i]++;
        if (ph[i] >= i + 1 + int'(extra[i])) begin
          lv[i] = ~lv[i]; ph[i] = 0; extra[i] = 1'b0;
        end
      end
    end
    div2 = lv[0]; div4 = lv[1]; div6 = lv[2];
  endtask

  // Evaluated at each posedge with the inputs the DUT is sampling at that edge.
  task automatic model_edge();
    bit d, rise;
    int p;
    d = 1'b0;
    edge_no++;
    if (reset) begin
      m_mode = 0; m_active = 0; m_pending = 0; m_armed = 0; m_period = 0;
      ms = '{0, 0, 0}; mp = '{0, 0, 0};
    end else begin
      rise = ms[m_active] && !mp[m_active];
      case (m_mode)
        0: begin
          d = ms[m_active];
          if (rise) begin
            p = edge_no - m_last;
            if (p > 15) p = 15;
            evq.push_back('{edge_no, m_armed, p, m_armed && (p != 2 * (m_active + 1))});
            if (m_armed) m_period = p;
            m_armed = 1'b1;
            m_last = edge_no;
          end
          if (sel_load && sel != 2'b11 && int'(sel) != m_active) begin
            m_pending = int'(sel); m_armed = 1'b0; m_mode = 1;
          end
        end
        1: begin
          d = ms[m_active];
          if (!ms[m_active]) m_mode = 2;
        end
        default: begin
          if (!ms[m_pending]) begin m_active = m_pending; m_mode = 0; end
        end
      endcase
      mp = ms;
      ms = '{div2, div4, div6};
    end
    cyq.push_back('{d, m_mode != 0, m_period});
  endtask

  task automatic step(input bit r, input bit ld, input logic [1:0] s);
    reset = r; sel_load = ld; sel = s;
    gen_sources();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (cyq.size() > 0) begin
      cy_t c;
      ev_t e;
      c = cyq.pop_front();
      check("div_out", 32'(div_out), 32'(c.div));
      check("switching", 32'(switching), 32'(c.sw));
      check("period_hold", 32'(period), 32'(c.per));
      if (evq.size() > 0 && evq[0].cyc < edge_no) begin
        e = evq.pop_front();
        check("rise_pulse_missed", 32'(0), 32'(1));
      end
      if (rise_pulse === 1'b1) begin
        if (evq.size() == 0 || evq[0].cyc != edge_no) begin
          check("rise_pulse_unexpected", 32'(1), 32'(0));
        end else begin
          e = evq.pop_front();
          check("period_valid", 32'(period_valid), 32'(e.pv));
          if (e.pv) check("period_value", 32'(period), 32'(e.per));
          check("period_err", 32'(period_err), 32'(e.perr));
        end
      end else begin
        check("rise_pulse", 32'(rise_pulse), 32'(0));
        check("period_valid_idle", 32'(period_valid), 32'(0));
        check("period_err_idle", 32'(period_err), 32'(0));
      end
    end
  end

  initial begin
    step(1, 0, 2'b00);
    step(1, 0, 2'b00);
    repeat (20) step(0, 0, 2'b00);
    step(0, 1, 2'b01);
    repeat (3) step(0, 0, 2'b01);
    step(0, 1, 2'b00);
    repeat (40) step(0, 0, 2'b00);
    step(0, 1, 2'b10);
    repeat (50) step(0, 0, 2'b10);
    step(0, 1, 2'b11);
    repeat (10) step(0, 0, 2'b11);
    step(0, 1, 2'b10);
    repeat (10) step(0, 0, 2'b10);
    step(0, 1, 2'b01);
    repeat (40) step(0, 0, 2'b01);
    stretch_req[1] = 1'b1;
    repeat (30) step(0, 0, 2'b01);
    hold4 = 20;
    repeat (40) step(0, 0, 2'b01);
    step(0, 1, 2'b00);
    step(1, 0, 2'b00);
    repeat (30) step(0, 0, 2'b00);
    repeat (3000) begin
      bit r, ld;
      logic [1:0] s;
      r  = ($urandom_range(0, 499) == 0);
      ld = ($urandom_range(0, 15) == 0);
      s  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) stretch_req[$urandom_range(0, 2)] = 1'b1;
      if ($urandom_range(0, 999) == 0 && hold4 == 0) hold4 = $urandom_range(5, 25);
      step(r, ld, s);
    end
    @(negedge clk);
    #1;
    check("event_queue_drained", 32'(evq.size()), 32'(0));
    check("cycle_queue_drained", 32'(cyq.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
